// File: rtl/io_sched.sv
// io_sched: processor I/O port scheduler.
//   Input side: one FIFO per source channel. The processor reads a channel
//   with zero latency (proc_din is combinational). A read of an empty FIFO
//   returns the last word popped from that channel and raises a sticky
//   underflow flag.
//   Output side: one data register and valid bit per sink channel. A write
//   that lands while the previous word is still unaccepted raises a sticky
//   overrun flag. The new word replaces the old one.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   proc_req_in, proc_addr_in         processor input-port read strobe and channel
//   proc_din                          word returned to the processor (combinational)
//   proc_out_en, proc_addr_out        processor output-port write strobe and channel
//   proc_dout                         word written by the processor
//   src_data, src_valid, src_ready    per-channel source handshake, packed by channel
//   snk_data, snk_valid, snk_ready    per-channel sink handshake, packed by channel
//   clr_err, err_unf, err_ovr         sticky error flags and their clear
module io_sched #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int AWID   = 1,
  parameter int FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AWID-1:0]          proc_addr_in,
  output logic [NUBITS-1:0]        proc_din,
  input  logic                     proc_out_en,
  input  logic [AWID-1:0]          proc_addr_out,
  input  logic [NUBITS-1:0]        proc_dout,
  input  logic [NUIOIN*NUBITS-1:0] src_data,
  input  logic [NUIOIN-1:0]        src_valid,
  output logic [NUIOIN-1:0]        src_ready,
  output logic [NUIOOU*NUBITS-1:0] snk_data,
  output logic [NUIOOU-1:0]        snk_valid,
  input  logic [NUIOOU-1:0]        snk_ready,
  input  logic                     clr_err,
  output logic [NUIOIN-1:0]        err_unf,
  output logic [NUIOOU-1:0]        err_ovr
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH) + 1;
  localparam logic [CW-1:0] FULL  = CW'(FDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(FDEPTH - 1);

  logic [NUBITS-1:0] mem_q    [NUIOIN][FDEPTH];
  logic [PW-1:0]     wr_ptr_q [NUIOIN];
  logic [PW-1:0]     wr_ptr_d [NUIOIN];
  logic [PW-1:0]     rd_ptr_q [NUIOIN];
  logic [PW-1:0]     rd_ptr_d [NUIOIN];
  logic [CW-1:0]     cnt_q    [NUIOIN];
  logic [CW-1:0]     cnt_d    [NUIOIN];
  logic [NUBITS-1:0] hold_q   [NUIOIN];
  logic [NUBITS-1:0] hold_d   [NUIOIN];
  logic [NUIOIN-1:0] rd_sel, push, pop, unf_evt;
  logic [NUIOIN-1:0] err_unf_q, err_unf_d;

  logic [NUIOOU*NUBITS-1:0] snk_data_q, snk_data_d;
  logic [NUIOOU-1:0]        snk_valid_q, snk_valid_d;
  logic [NUIOOU-1:0]        wr_sel, ovr_evt;
  logic [NUIOOU-1:0]        err_ovr_q, err_ovr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  // Input channels
  always_comb begin
    proc_din = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      // Gating with rst keeps sources stalled for the whole reset cycle.
      src_ready[k] = rst && (cnt_q[k] != FULL);
      push[k]      = src_valid[k] && src_ready[k];
      // An out-of-range address never matches a channel, so it reads 0 and changes nothing.
      rd_sel[k]    = proc_req_in && (int'(proc_addr_in) == k);
      pop[k]       = rd_sel[k] && (cnt_q[k] != '0);
      unf_evt[k]   = rd_sel[k] && (cnt_q[k] == '0);
      if (rd_sel[k])
        proc_din = (cnt_q[k] != '0) ? mem_q[k][rd_ptr_q[k]] : hold_q[k];

      // An empty FIFO never bypasses a same-cycle push to the reader.
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
      wr_ptr_d[k]  = push[k] ? ptr_inc(wr_ptr_q[k]) : wr_ptr_q[k];
      rd_ptr_d[k]  = pop[k]  ? ptr_inc(rd_ptr_q[k]) : rd_ptr_q[k];
      hold_d[k]    = pop[k]  ? mem_q[k][rd_ptr_q[k]] : hold_q[k];
      // A new event wins over a same-cycle clear.
      err_unf_d[k] = (err_unf_q[k] & ~clr_err) | unf_evt[k];
    end
  end

  // Output channels
  always_comb begin
    snk_data_d  = snk_data_q;
    snk_valid_d = snk_valid_q;
    for (int j = 0; j < NUIOOU; j++) begin
      wr_sel[j]  = proc_out_en && (int'(proc_addr_out) == j);
      ovr_evt[j] = wr_sel[j] && snk_valid_q[j] && !snk_ready[j];
      if (wr_sel[j]) begin
        snk_data_d[j*NUBITS +: NUBITS] = proc_dout;
        snk_valid_d[j]                 = 1'b1;
      end else if (snk_valid_q[j] && snk_ready[j]) begin
        snk_valid_d[j] = 1'b0;
      end
      err_ovr_d[j] = (err_ovr_q[j] & ~clr_err) | ovr_evt[j];
    end
  end

  // FIFO storage has no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUIOIN; k++)
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= src_data[k*NUBITS +: NUBITS];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUIOIN; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        hold_q[k]   <= '0;
      end
      err_unf_q   <= '0;
      snk_data_q  <= '0;
      snk_valid_q <= '0;
      err_ovr_q   <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        cnt_q[k]    <= cnt_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        hold_q[k]   <= hold_d[k];
      end
      err_unf_q   <= err_unf_d;
      snk_data_q  <= snk_data_d;
      snk_valid_q <= snk_valid_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign snk_data  = snk_data_q;
  assign snk_valid = snk_valid_q;
  assign err_unf   = err_unf_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_io_sched.sv
// Directed bench for io_sched with default parameters. Words pushed into
// channel 0 go into a queue; each processor read pops the expected word.
module tb_io_sched;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          proc_req_in = 1'b0;
  logic [0:0]    proc_addr_in = '0;
  logic [NB-1:0] proc_din;
  logic          proc_out_en = 1'b0;
  logic [0:0]    proc_addr_out = '0;
  logic [NB-1:0] proc_dout = '0;
  logic [2*NB-1:0] src_data = '0;
  logic [1:0]    src_valid = '0;
  logic [1:0]    src_ready;
  logic [2*NB-1:0] snk_data;
  logic [1:0]    snk_valid;
  logic [1:0]    snk_ready = '0;
  logic          clr_err = 1'b0;
  logic [1:0]    err_unf;
  logic [1:0]    err_ovr;

  int total = 0;
  int bad   = 0;
  logic [NB-1:0] q0[$];
  logic [NB-1:0] hold0 = '0;
  logic [NB-1:0] exp_w, w;

  io_sched dut (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .proc_addr_in(proc_addr_in), .proc_din(proc_din),
    .proc_out_en(proc_out_en), .proc_addr_out(proc_addr_out), .proc_dout(proc_dout),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .clr_err(clr_err), .err_unf(err_unf), .err_ovr(err_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_src_ready", 64'(src_ready), 64'h0);
    chk("rst_snk_valid", 64'(snk_valid), 64'h0);
    chk("rst_snk_data", snk_data, 64'h0);
    chk("rst_err_unf", 64'(err_unf), 64'h0);
    chk("rst_err_ovr", 64'(err_ovr), 64'h0);
    chk("rst_din", 64'(proc_din), 64'h0);
    rst = 1'b1;
    #1;
    chk("post_rst_src_ready", 64'(src_ready), 64'h3);

    // Fill channel 0, refuse a fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      src_valid[0] = 1'b1;
      src_data[NB-1:0] = NB'(32'h11 * (i + 1));
      q0.push_back(NB'(32'h11 * (i + 1)));
      tick();
    end
    chk("full_ready", 64'(src_ready[0]), 64'h0);
    src_data[NB-1:0] = 32'h55;
    tick();
    src_valid = '0;
    chk("full_refused_ready", 64'(src_ready[0]), 64'h0);
    for (int i = 0; i < 4; i++) begin
      proc_req_in = 1'b1;
      proc_addr_in = 1'b0;
      #1;
      exp_w = q0.pop_front();
      hold0 = exp_w;
      chk("fifo_order", 64'(proc_din), 64'(exp_w));
      tick();
    end
    proc_req_in = 1'b0;
    #1;
    chk("req_low_din", 64'(proc_din), 64'h0);
    chk("drain_no_unf", 64'(err_unf), 64'h0);
    chk("drain_ready", 64'(src_ready), 64'h3);

    // Channel 1 underflow returns last popped word; clear priority
    src_valid = 2'b10;
    src_data[2*NB-1:NB] = 32'h5A;
    tick();
    src_valid = '0;
    proc_req_in = 1'b1;
    proc_addr_in = 1'b1;
    #1;
    chk("ch1_pop", 64'(proc_din), 64'h5A);
    tick();
    chk("ch1_empty_read", 64'(proc_din), 64'h5A);
    tick();
    proc_req_in = 1'b0;
    chk("unf_set", 64'(err_unf), 64'h2);
    clr_err = 1'b1;
    proc_req_in = 1'b1;
    tick();
    chk("clr_priority", 64'(err_unf), 64'h2);
    proc_req_in = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("clr_err", 64'(err_unf), 64'h0);

    // Same-cycle push and read on empty channel 0: no bypass
    src_valid = 2'b01;
    src_data[NB-1:0] = 32'h77;
    proc_req_in = 1'b1;
    proc_addr_in = 1'b0;
    #1;
    chk("nobypass_din", 64'(proc_din), 64'(hold0));
    q0.push_back(32'h77);
    tick();
    src_valid = '0;
    chk("same_cycle_unf", 64'(err_unf), 64'h1);
    exp_w = q0.pop_front();
    hold0 = exp_w;
    chk("stored_push", 64'(proc_din), 64'(exp_w));
    tick();
    proc_req_in = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Output overrun and handshake-write behaviour
    snk_ready = '0;
    proc_out_en = 1'b1;
    proc_addr_out = 1'b1;
    proc_dout = 32'hA5;
    tick();
    chk("ovr_first", 64'(err_ovr), 64'h0);
    chk("snk_valid_a5", 64'(snk_valid), 64'h2);
    chk("snk_data_a5", 64'(snk_data[2*NB-1:NB]), 64'hA5);
    proc_dout = 32'hB6;
    tick();
    chk("ovr_set", 64'(err_ovr), 64'h2);
    chk("snk_data_b6", 64'(snk_data[2*NB-1:NB]), 64'hB6);
    proc_out_en = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_clr", 64'(err_ovr), 64'h0);
    chk("valid_held", 64'(snk_valid), 64'h2);
    snk_ready = 2'b10;
    proc_out_en = 1'b1;
    proc_dout = 32'hC7;
    tick();
    chk("hs_write_no_ovr", 64'(err_ovr), 64'h0);
    chk("hs_write_valid", 64'(snk_valid), 64'h2);
    chk("hs_write_data", 64'(snk_data[2*NB-1:NB]), 64'hC7);
    proc_out_en = 1'b0;
    tick();
    chk("drain_valid", 64'(snk_valid), 64'h0);
    snk_ready = '0;
    proc_out_en = 1'b1;
    proc_addr_out = 1'b0;
    proc_dout = 32'hE0;
    tick();
    chk("ch0_write", snk_data, {32'hC7, 32'hE0});
    chk("ch0_valid", 64'(snk_valid), 64'h1);
    proc_dout = 32'hE1;
    tick();
    proc_out_en = 1'b0;
    chk("ovr_ch0", 64'(err_ovr), 64'h1);

    // Mid-operation reset discards FIFO content
    src_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      src_data[NB-1:0] = NB'(32'hD1 + i);
      tick();
    end
    src_valid = '0;
    rst = 1'b0;
    tick();
    chk("in_rst_ready", 64'(src_ready), 64'h0);
    rst = 1'b1;
    q0.delete();
    hold0 = '0;
    #1;
    chk("mid_rst_ready", 64'(src_ready), 64'h3);
    chk("mid_rst_valid", 64'(snk_valid), 64'h0);
    chk("mid_rst_data", snk_data, 64'h0);
    chk("mid_rst_ovr", 64'(err_ovr), 64'h0);
    chk("mid_rst_unf", 64'(err_unf), 64'h0);
    proc_req_in = 1'b1;
    proc_addr_in = 1'b0;
    #1;
    chk("post_rst_read", 64'(proc_din), 64'(hold0));
    tick();
    proc_req_in = 1'b0;
    chk("post_rst_unf", 64'(err_unf), 64'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Full-rate push/pop across two pointer wraps
    for (int i = 0; i <= 10; i++) begin
      src_valid[0] = (i < 10);
      w = $urandom;
      src_data[NB-1:0] = w;
      proc_req_in = (i > 0);
      proc_addr_in = 1'b0;
      #1;
      if (i > 0) begin
        exp_w = q0.pop_front();
        chk("wrap_order", 64'(proc_din), 64'(exp_w));
      end
      if (i < 10) q0.push_back(w);
      chk("wrap_ready", 64'(src_ready[0]), 64'h1);
      tick();
    end
    src_valid = '0;
    proc_req_in = 1'b0;
    #1;
    chk("wrap_no_unf", 64'(err_unf), 64'h0);
    chk("wrap_empty_ready", 64'(src_ready), 64'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
